// File: rtl/game_pkg.sv
// Shared game types and constants: FSM state encoding, score width, and the
// saturating score adder used by the score keeper.
package game_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2
    } state_t;

    localparam int SCORE_W       = 14;
    localparam int MAX_SCORE_DEF = 9999;

    // The sum is one bit wider than the score, so the carry is never lost before the clamp.
    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] score,
        input logic [SCORE_W:0]   inc,
        input logic [SCORE_W-1:0] ceiling
    );
        logic [SCORE_W:0] sum;
        sum = {1'b0, score} + inc;
        return (sum > {1'b0, ceiling}) ? ceiling : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Wrapping divider: counts 0..TICK_DIV-1 while enabled and pulses tick for
// one cycle on the wrap. clr forces the count to zero and wins over en.
module tick_gen #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/score_keeper.sv
// Per-game score FSM: distance points on a divided tick plus coin bonuses,
// saturating at MAX_SCORE, with a session high score captured at game end.
module score_keeper
    import game_pkg::*;
#(
    parameter int TICK_DIV   = 10_000_000,
    parameter int COIN_VALUE = 10,
    parameter int MAX_SCORE  = MAX_SCORE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               coin,
    input  logic               gameover,
    output logic [SCORE_W-1:0] binary,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high,
    output logic               running
);

    localparam logic [SCORE_W:0]   COIN_INC = (SCORE_W + 1)'(COIN_VALUE);
    localparam logic [SCORE_W:0]   TICK_INC = (SCORE_W + 1)'(1);
    localparam logic [SCORE_W-1:0] CEILING  = SCORE_W'(MAX_SCORE);

    state_t             state, state_nxt;
    logic               tick;
    logic               game_start;
    logic               game_end;
    logic               score_upd;
    logic [SCORE_W:0]   inc;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (game_start),
        .en    (running),
        .tick  (tick)
    );

    always_comb begin
        state_nxt  = state;
        game_start = 1'b0;
        game_end   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt  = S_RUN;
                    game_start = 1'b1;
                end
            end
            S_RUN: begin
                if (gameover) begin
                    state_nxt = S_OVER;
                    game_end  = 1'b1;
                end
            end
            // start outranks a held gameover here
            S_OVER: begin
                if (start) begin
                    state_nxt  = S_RUN;
                    game_start = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // gameover drops any tick/coin that lands in the same cycle
    assign score_upd = (state == S_RUN) && !gameover && (tick || coin);
    assign inc       = (tick ? TICK_INC : '0) + (coin ? COIN_INC : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == S_RUN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            binary <= '0;
        end else if (game_start) begin
            binary <= '0;
        end else if (score_upd) begin
            binary <= sat_add(binary, inc, CEILING);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_score <= '0;
            new_high   <= 1'b0;
        end else if (game_start) begin
            new_high   <= 1'b0;
        end else if (game_end && (binary > high_score)) begin
            high_score <= binary;
            new_high   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with TICK_DIV=4: tick cadence, coin/tick
// merge, saturation, high-score capture, start/gameover priority, async reset.
module tb_score_keeper;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        coin;
    logic        gameover;
    logic [13:0] binary;
    logic [13:0] high_score;
    logic        new_high;
    logic        running;

    int n_tests = 0;
    int n_fail  = 0;

    score_keeper #(
        .TICK_DIV   (4),
        .COIN_VALUE (10),
        .MAX_SCORE  (9999)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .coin       (coin),
        .gameover   (gameover),
        .binary     (binary),
        .high_score (high_score),
        .new_high   (new_high),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n edges; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Run ncyc RUN cycles, with a coin in each of the first ncoin cycles.
    task automatic play(input int ncyc, input int ncoin);
        for (int k = 1; k <= ncyc; k++) begin
            coin = (k <= ncoin);
            step(1);
        end
        coin = 1'b0;
    endtask

    task automatic end_game(input logic with_coin);
        gameover = 1'b1;
        coin     = with_coin;
        step(1);
        gameover = 1'b0;
        coin     = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        coin     = 1'b0;
        gameover = 1'b0;
        #3;
        chk("rst_binary",  int'(binary),     0);
        chk("rst_high",    int'(high_score), 0);
        chk("rst_newhigh", int'(new_high),   0);
        chk("rst_running", int'(running),    0);
        step(2);
        rst_n = 1'b1;

        // 1: 40 RUN cycles -> 10 ticks; then exactly one step per 4 cycles
        pulse_start();
        chk("t1_running_entry", int'(running), 1);
        step(40);
        chk("t1_running", int'(running), 1);
        chk("t1_binary10", int'(binary), 10);
        step(3);
        chk("t1_no_tick_yet", int'(binary), 10);
        step(1);
        chk("t1_tick11", int'(binary), 11);

        // 2: coin coincident with tick at score 5 -> 16
        do_reset();
        pulse_start();
        step(20);
        chk("t2_score5", int'(binary), 5);
        step(3);
        chk("t2_hold5", int'(binary), 5);
        coin = 1'b1;
        step(1);
        coin = 1'b0;
        chk("t2_coin_tick16", int'(binary), 16);
        coin = 1'b1;
        step(1);
        coin = 1'b0;
        chk("t2_coin_only26", int'(binary), 26);

        // 3: 975 coins -> 9750 + 243 ticks = 9993; +2 ticks = 9995; coin saturates
        do_reset();
        pulse_start();
        play(975, 975);
        chk("t3_preload9993", int'(binary), 9993);
        step(5);
        chk("t3_preload9995", int'(binary), 9995);
        coin = 1'b1;
        step(1);
        coin = 1'b0;
        chk("t3_sat_coin", int'(binary), 9999);
        step(8);
        chk("t3_sat_ticks", int'(binary), 9999);

        // 4: 3 coins + 7 ticks = 37, gameover with coincident coin
        do_reset();
        pulse_start();
        play(28, 3);
        chk("t4_score37", int'(binary), 37);
        end_game(1'b1);
        chk("t4_over_binary", int'(binary),     37);
        chk("t4_over_high",   int'(high_score), 37);
        chk("t4_over_newhi",  int'(new_high),   1);
        chk("t4_over_run",    int'(running),    0);
        coin = 1'b1;
        step(8);
        coin = 1'b0;
        chk("t4_frozen", int'(binary), 37);
        pulse_start();
        chk("t4_restart_bin",   int'(binary),     0);
        chk("t4_restart_newhi", int'(new_high),   0);
        chk("t4_restart_high",  int'(high_score), 37);
        chk("t4_restart_run",   int'(running),    1);

        // 5: tie does not set new_high; lower score leaves high_score alone
        play(28, 3);
        end_game(1'b0);
        chk("t5_tie_bin",   int'(binary),     37);
        chk("t5_tie_high",  int'(high_score), 37);
        chk("t5_tie_newhi", int'(new_high),   0);
        pulse_start();
        play(8, 1);
        end_game(1'b0);
        chk("t5_low_bin",   int'(binary),     12);
        chk("t5_low_high",  int'(high_score), 37);
        chk("t5_low_newhi", int'(new_high),   0);

        // start and held gameover together in OVER: start wins
        start    = 1'b1;
        gameover = 1'b1;
        step(1);
        start    = 1'b0;
        gameover = 1'b0;
        chk("t5_start_wins_run", int'(running), 1);
        chk("t5_start_wins_bin", int'(binary),  0);

        // start mid-game is ignored
        step(8);
        pulse_start();
        chk("t5_start_in_run", int'(binary), 2);

        // 6: async reset between edges mid-RUN
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_bin",  int'(binary),     0);
        chk("t6_async_high", int'(high_score), 0);
        chk("t6_async_run",  int'(running),    0);
        step(1);
        rst_n    = 1'b1;
        coin     = 1'b1;
        gameover = 1'b1;
        step(6);
        coin     = 1'b0;
        gameover = 1'b0;
        chk("t6_idle_bin", int'(binary),  0);
        chk("t6_idle_run", int'(running), 0);
        pulse_start();
        chk("t6_idle_to_run", int'(running), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
